// File: rtl/membus_arbiter_pkg.sv
// Shared core bus definitions (package eei) used by the memory bus arbiter.
package eei;

  localparam int XLEN              = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;
  localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } MemOwner;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/membus_arbiter.sv
// Two-to-one ibus/dbus arbiter for the single-outstanding core memory bus.
// Optional macro MEMBUS_ARBITER_ANTI_STARVE_EN bounds consecutive dbus wins while ibus waits.
module membus_arbiter
  import eei::*;
#(
  parameter int ADDR_WIDTH   = XLEN,
  parameter int DATA_WIDTH   = MEMBUS_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ibus_valid,
  output logic                    ibus_ready,
  input  logic [ADDR_WIDTH-1:0]   ibus_addr,
  output logic                    ibus_rvalid,
  output logic [DATA_WIDTH-1:0]   ibus_rdata,
  input  logic                    dbus_valid,
  output logic                    dbus_ready,
  input  logic [ADDR_WIDTH-1:0]   dbus_addr,
  input  logic                    dbus_wen,
  input  logic [DATA_WIDTH-1:0]   dbus_wdata,
  input  logic [DATA_WIDTH/8-1:0] dbus_wmask,
  output logic                    dbus_rvalid,
  output logic [DATA_WIDTH-1:0]   dbus_rdata,
  output logic                    mbus_valid,
  input  logic                    mbus_ready,
  output logic [ADDR_WIDTH-1:0]   mbus_addr,
  output logic                    mbus_wen,
  output logic [DATA_WIDTH-1:0]   mbus_wdata,
  output logic [DATA_WIDTH/8-1:0] mbus_wmask,
  input  logic                    mbus_rvalid,
  input  logic [DATA_WIDTH-1:0]   mbus_rdata
);

  arb_state_e state, next_state;
  logic       free;
  logic       grant_i;
  logic       grant_d;
  logic       prio_i;

`ifdef MEMBUS_ARBITER_ANTI_STARVE_EN
  localparam int CNT_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;

  logic [CNT_W-1:0] starve_cnt;

  // Count dbus acceptances that happened while ibus was left waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= {CNT_W{1'b0}};
    end else if (!ibus_valid || (grant_i && mbus_ready)) begin
      starve_cnt <= {CNT_W{1'b0}};
    end else if (grant_d && mbus_ready && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  assign prio_i = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign prio_i = 1'b0;
`endif

  // Outstanding-transaction state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant, request mux, response routing and next state.
  always_comb begin
    free        = (state == IDLE) | mbus_rvalid;
    grant_d     = free & dbus_valid & ~(prio_i & ibus_valid);
    grant_i     = free & ibus_valid & ~grant_d;
    next_state  = state;
    mbus_addr   = {ADDR_WIDTH{1'b0}};
    mbus_wen    = 1'b0;
    mbus_wdata  = {DATA_WIDTH{1'b0}};
    mbus_wmask  = {(DATA_WIDTH/8){1'b0}};
    ibus_rvalid = 1'b0;
    dbus_rvalid = 1'b0;

    if (grant_d) begin
      mbus_addr  = dbus_addr;
      mbus_wen   = dbus_wen;
      mbus_wdata = dbus_wdata;
      mbus_wmask = dbus_wmask;
    end else if (grant_i) begin
      mbus_addr  = ibus_addr;
    end else begin
      mbus_addr  = {ADDR_WIDTH{1'b0}};
    end

    // A response retires the owner; a stray response in IDLE goes nowhere.
    case (state)
      WAIT_I: begin
        ibus_rvalid = mbus_rvalid & ~rst;
        if (mbus_rvalid) next_state = IDLE;
        else             next_state = WAIT_I;
      end
      WAIT_D: begin
        dbus_rvalid = mbus_rvalid & ~rst;
        if (mbus_rvalid) next_state = IDLE;
        else             next_state = WAIT_D;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if ((grant_i | grant_d) && mbus_ready) begin
      next_state = grant_d ? WAIT_D : WAIT_I;
    end else begin
      next_state = next_state;
    end
  end

  assign mbus_valid = (grant_i | grant_d) & ~rst;
  assign ibus_ready = grant_i & mbus_ready & ~rst;
  assign dbus_ready = grant_d & mbus_ready & ~rst;
  assign ibus_rdata = mbus_rdata;
  assign dbus_rdata = mbus_rdata;

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Two-to-one arbiter sharing the single core memory bus between instruction fetch (ibus) and load/store/AMO (dbus).
- Supports one outstanding transaction at a time.
- Sits between the fetch and memory stages and the mmio/RAM/ROM decoder.
- Routes each response back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 64 (eei::XLEN), bus address width.
- DATA_WIDTH, 64 (eei::MEMBUS_DATA_WIDTH), bus data width; mask width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive dbus grants tolerated while ibus waits; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ibus_valid  in  1  fetch request.
- ibus_ready  out  1  fetch request accepted.
- ibus_addr  in  ADDR_WIDTH  fetch address.
- ibus_rvalid  out  1  fetch response valid.
- ibus_rdata  out  DATA_WIDTH  fetch response data.
- dbus_valid  in  1  data request.
- dbus_ready  out  1  data request accepted.
- dbus_addr  in  ADDR_WIDTH  data address.
- dbus_wen  in  1  write enable.
- dbus_wdata  in  DATA_WIDTH  write data.
- dbus_wmask  in  DATA_WIDTH/8  byte mask.
- dbus_rvalid  out  1  data response valid.
- dbus_rdata  out  DATA_WIDTH  data response data.
- mbus_valid  out  1  downstream request.
- mbus_ready  in  1  downstream accept.
- mbus_addr  out  ADDR_WIDTH  downstream address.
- mbus_wen  out  1  downstream write enable.
- mbus_wdata  out  DATA_WIDTH  downstream write data.
- mbus_wmask  out  DATA_WIDTH/8  downstream mask.
- mbus_rvalid  in  1  downstream response valid.
- mbus_rdata  in  DATA_WIDTH  downstream response data.

Behaviour:
- FSM states:
  - IDLE: no outstanding transaction.
  - WAIT_I: fetch transaction outstanding.
  - WAIT_D: data transaction outstanding.
- Reset:
  - rst asserted → state=IDLE, owner cleared, starve counter=0.
  - While rst is high, all *_ready, *_rvalid and mbus_valid = 0.
- Free condition: `free = (state==IDLE) | mbus_rvalid`. A new request may issue in the same cycle as the previous response.
- Grant (combinational, only when free):
  - dbus has priority over ibus.
  - grant_d = free & dbus_valid.
  - grant_i = free & ibus_valid & !dbus_valid.
- Request path:
  - mbus_valid = grant_i | grant_d.
  - mbus_addr/wen/wdata/wmask are muxed from the winner. ibus drives wen=0, wdata=0, wmask=0.
  - When no grant, mbus_* payload = 0.
- Ready:
  - ibus_ready = grant_i & mbus_ready.
  - dbus_ready = grant_d & mbus_ready.
  - The loser's ready stays 0.
- Request-handshake transitions:
  - mbus_valid & mbus_ready → next state WAIT_D if grant_d, else WAIT_I.
  - mbus_valid & !mbus_ready → grant is re-evaluated next cycle; requesters must hold valid and payload.
- Response routing:
  - In WAIT_I: ibus_rvalid = mbus_rvalid.
  - In WAIT_D: dbus_rvalid = mbus_rvalid.
  - Both *_rdata = mbus_rdata unconditionally; consumers qualify with rvalid.
- Response transitions:
  - Response without a new accept → IDLE.
  - Response with a new accept → WAIT_x of the new winner.
- Boundary cases:
  - mbus_rvalid in IDLE is ignored: no rvalid is forwarded and the state is unchanged.
  - rst mid-transaction drops the outstanding transaction; a later stale mbus_rvalid arrives in IDLE and is ignored.
- Latency: zero added cycles for both request and response (purely combinational forwarding plus the owner register).

Optional Feature:
- Macro: MEMBUS_ARBITER_ANTI_STARVE_EN.
- When defined:
  - A 3-bit-minimum counter (width $clog2(STARVE_LIMIT+1)) increments on each accepted dbus transfer while ibus_valid=1.
  - The counter resets to 0 on any accepted ibus transfer, or when ibus_valid=0.
  - When counter == STARVE_LIMIT, priority flips to ibus for the next grant only.
- When undefined: strict dbus priority; no counter is instantiated.

Decomposition:
- Package eei gets:
  - typedef MemOwner enum logic [1:0] {OWN_NONE, OWN_I, OWN_D}.
  - localparam MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH/8.
- No sub-module is needed. The starve counter is an inline always_ff under the macro.

Test Plan:
- ibus_valid only, addr=0x1000, mbus_ready=1 → mbus_addr=0x1000 and ibus_ready=1 same cycle; mbus_rvalid=1 with rdata=0xDEAD_BEEF two cycles later → ibus_rvalid=1 with that data; dbus_rvalid=0.
- ibus and dbus valid together, dbus addr=0x8000_0010, wen=1, wdata=0x55, wmask=0x01 → dbus wins (dbus_ready=1, ibus_ready=0, mbus_wen=1); ibus is granted in the cycle dbus's rvalid returns.
- mbus_ready=0 for 3 cycles with dbus_valid held → mbus_valid=1 each cycle, dbus_ready=0; accepted on cycle 4; state becomes WAIT_D.
- Stray mbus_rvalid=1 in IDLE → ibus_rvalid=dbus_rvalid=0; state remains IDLE.
- rst pulsed while in WAIT_I, then mbus_rvalid=1 → no rvalid forwarded; the next ibus request is granted normally.
- With MEMBUS_ARBITER_ANTI_STARVE_EN and STARVE_LIMIT=4, both valid continuously with mbus_ready=1 and rvalid the next cycle → grant order D,D,D,D,I,D,…
